// File: rtl/master_bus_requester.sv
// Master-side requester for the bus arbiter: serialises the slave select after a local go,
// holds the request until grant, and tracks ownership across split suspend/resume until trans_done.
module master_bus_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       go,
    input  logic [1:0] slave_id,
    input  logic       arbiter_busy,
    input  logic       bus_busy,
    input  logic       m_grant,
    input  logic       trans_done,
    output logic       m_request,
    output logic       m_slave_sel,
    output logic       ready,
    output logic       granted,
    output logic       suspended,
    output logic       done,
    output logic       err_timeout,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PEND       = 3'd1,
        ST_ADDR0      = 3'd2,
        ST_ADDR1      = 3'd3,
        ST_WAIT_GRANT = 3'd4,
        ST_OWN        = 3'd5,
        ST_SPLIT_WAIT = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       slv_q, slv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic m_request_q,   m_request_d;
    logic m_slave_sel_q, m_slave_sel_d;
    logic ready_q,       ready_d;
    logic granted_q,     granted_d;
    logic suspended_q,   suspended_d;
    logic done_q,        done_d;
    logic err_timeout_q, err_timeout_d;

    // Next-state logic; every output is derived from the next state so it lands on the same edge.
    always_comb begin
        state_d       = state_q;
        slv_d         = slv_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    slv_d   = slave_id;
                    state_d = (!arbiter_busy && !bus_busy) ? ST_ADDR0 : ST_PEND;
                end
            end
            ST_PEND: begin
                if (!arbiter_busy && !bus_busy) begin
                    state_d = ST_ADDR0;
                end
            end
            ST_ADDR0: begin
                state_d = ST_ADDR1;
            end
            ST_ADDR1: begin
                state_d = ST_WAIT_GRANT;
                cnt_d   = '0;
            end
            ST_WAIT_GRANT: begin
                // Grant beats timeout when both land on the last counted cycle.
                if (m_grant) begin
                    state_d = ST_OWN;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d       = ST_IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OWN: begin
                if (trans_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (!m_grant) begin
                    state_d = ST_SPLIT_WAIT;
                end
            end
            ST_SPLIT_WAIT: begin
                // trans_done here belongs to whichever master holds the bus during the split.
                if (m_grant) begin
                    state_d = ST_OWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        m_request_d   = 1'b0;
        m_slave_sel_d = 1'b0;
        ready_d       = 1'b0;
        granted_d     = 1'b0;
        suspended_d   = 1'b0;

        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_ADDR0: begin
                m_request_d   = 1'b1;
                m_slave_sel_d = slv_d[0];
            end
            ST_ADDR1: begin
                m_request_d   = 1'b1;
                m_slave_sel_d = slv_d[1];
            end
            ST_WAIT_GRANT: begin
                m_request_d = 1'b1;
            end
            ST_OWN: begin
                m_request_d = 1'b1;
                granted_d   = 1'b1;
            end
            ST_SPLIT_WAIT: begin
                m_request_d = 1'b1;
                suspended_d = 1'b1;
            end
            default: begin
                m_request_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            slv_q         <= 2'b00;
            cnt_q         <= '0;
            m_request_q   <= 1'b0;
            m_slave_sel_q <= 1'b0;
            ready_q       <= 1'b1;
            granted_q     <= 1'b0;
            suspended_q   <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slv_q         <= slv_d;
            cnt_q         <= cnt_d;
            m_request_q   <= m_request_d;
            m_slave_sel_q <= m_slave_sel_d;
            ready_q       <= ready_d;
            granted_q     <= granted_d;
            suspended_q   <= suspended_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign m_request   = m_request_q;
    assign m_slave_sel = m_slave_sel_q;
    assign ready       = ready_q;
    assign granted     = granted_q;
    assign suspended   = suspended_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_master_bus_requester.sv
// Directed bench for master_bus_requester with a short timeout so the abort path is reachable.
module tb_master_bus_requester;

    logic       sys_clk;
    logic       sys_rst;
    logic       go;
    logic [1:0] slave_id;
    logic       arbiter_busy;
    logic       bus_busy;
    logic       m_grant;
    logic       trans_done;
    logic       m_request;
    logic       m_slave_sel;
    logic       ready;
    logic       granted;
    logic       suspended;
    logic       done;
    logic       err_timeout;
    logic [2:0] dbg_state;

    int checks;
    int failures;

    master_bus_requester #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (8)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .go          (go),
        .slave_id    (slave_id),
        .arbiter_busy(arbiter_busy),
        .bus_busy    (bus_busy),
        .m_grant     (m_grant),
        .trans_done  (trans_done),
        .m_request   (m_request),
        .m_slave_sel (m_slave_sel),
        .ready       (ready),
        .granted     (granted),
        .suspended   (suspended),
        .done        (done),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected order: m_request, m_slave_sel, ready, granted, suspended, done, err_timeout.
    task automatic chk_out(input string tag, input logic req, input logic sel, input logic rdy,
                           input logic gnt, input logic sus, input logic dn, input logic er);
        chk({tag, ".m_request"},   m_request,   req);
        chk({tag, ".m_slave_sel"}, m_slave_sel, sel);
        chk({tag, ".ready"},       ready,       rdy);
        chk({tag, ".granted"},     granted,     gnt);
        chk({tag, ".suspended"},   suspended,   sus);
        chk({tag, ".done"},        done,        dn);
        chk({tag, ".err_timeout"}, err_timeout, er);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        sys_rst      = 1'b1;
        go           = 1'b0;
        slave_id     = 2'b00;
        arbiter_busy = 1'b0;
        bus_busy     = 1'b0;
        m_grant      = 1'b0;
        trans_done   = 1'b0;

        // Reset state
        #2;
        chk_out("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk3("reset.state", dbg_state, 3'd0);
        step();
        sys_rst = 1'b0;
        step();
        chk_out("idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bus free, slave 2'b10: address bits 0 then 1, grant, done
        go = 1'b1; slave_id = 2'b10;
        step(); go = 1'b0;
        chk_out("t1.addr0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t1.addr1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t1.wait0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("t1.wait1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_grant = 1'b1;
        step();
        chk_out("t1.own", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        trans_done = 1'b1;
        step(); trans_done = 1'b0; m_grant = 1'b0;
        chk_out("t1.done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back go in the done cycle with a new slave, then let it time out
        go = 1'b1; slave_id = 2'b01;
        step(); go = 1'b0;
        chk_out("b2b.addr0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("b2b.addr1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("to.wait0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step();
            chk_out($sformatf("to.wait%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step();
        chk_out("to.err", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("to.after", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pending while bus busy; go during PEND must not change the latched slave
        bus_busy = 1'b1; go = 1'b1; slave_id = 2'b11;
        step(); slave_id = 2'b00;
        chk_out("pend.0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            step();
            chk_out($sformatf("pend.%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus_busy = 1'b0;
        step(); go = 1'b0; m_grant = 1'b1;
        chk_out("pend.addr0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Early grant during the address phase is ignored
        step();
        chk_out("pend.addr1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("pend.wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("pend.own", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // go during OWN ignored
        go = 1'b1; slave_id = 2'b01;
        step(); go = 1'b0;
        chk_out("own.go_ign", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Split: grant low for 6 cycles, trans_done mid-split ignored
        m_grant = 1'b0;
        for (int i = 0; i < 6; i++) begin
            trans_done = (i == 3) ? 1'b1 : 1'b0;
            step();
            chk_out($sformatf("split.%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        trans_done = 1'b0; m_grant = 1'b1;
        step();
        chk_out("split.resume", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // trans_done together with grant drop is a completion, not a split
        trans_done = 1'b1; m_grant = 1'b0;
        step(); trans_done = 1'b0;
        chk_out("done_drop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("done_drop.idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Grant on the final timeout cycle wins
        go = 1'b1; slave_id = 2'b00;
        step(); go = 1'b0;
        step();
        step();
        chk_out("tg.wait0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) step();
        chk_out("tg.wait7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_grant = 1'b1;
        step();
        chk_out("tg.own", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Async reset mid-OWN
        sys_rst = 1'b1;
        #1;
        chk_out("rst_own", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk3("rst_own.state", dbg_state, 3'd0);
        m_grant = 1'b0;
        step(); sys_rst = 1'b0;
        go = 1'b1; slave_id = 2'b10;
        step(); go = 1'b0;
        chk_out("rst1.addr0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("rst1.addr1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset mid-ADDR1
        sys_rst = 1'b1;
        #1;
        chk_out("rst_addr1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); sys_rst = 1'b0;
        go = 1'b1; slave_id = 2'b01;
        step(); go = 1'b0;
        chk_out("rst2.addr0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_out("rst2.addr1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
